cpu_control_fsm: RTL and testbench

//  Multi-cycle control unit for the LEGv8 CPU datapath; the driving end of the datapath control interface.

---
 rtl/cpu_ctrl_pkg.sv | 52 +++++
 rtl/instr_classify.sv | 27 ++
 rtl/cpu_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_ctrl_pkg : shared types and constants for the LEGv8 control FSM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ADDI = 3'd0,
    C_ADDS = 3'd1,
    C_SUBS = 3'd2,
    C_LDUR = 3'd3,
    C_STUR = 3'd4,
    C_B    = 3'd5,
    C_CBZ  = 3'd6,
    C_ILL  = 3'd7
  } instr_class_t;

  // Opcode prefixes; each is compared against the top bits of instr[31:21].
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;

  function automatic logic is_mem_class(input instr_class_t cls);
    return (cls == C_LDUR) || (cls == C_STUR);
  endfunction

  function automatic logic is_imm_alu_class(input instr_class_t cls);
    return (cls == C_ADDI) || is_mem_class(cls);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_classify.sv
// +----------------------------------------------------------------------+
// | instr_classify : combinational opcode -> instruction class decoder    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_classify
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0]  opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = C_ILL;
    if (opcode[10:1] == OP_ADDI)      cls = C_ADDI;
    else if (opcode == OP_ADDS)       cls = C_ADDS;
    else if (opcode == OP_SUBS)       cls = C_SUBS;
    else if (opcode == OP_LDUR)       cls = C_LDUR;
    else if (opcode == OP_STUR)       cls = C_STUR;
    else if (opcode[10:5] == OP_B)    cls = C_B;
    else if (opcode[10:3] == OP_CBZ)  cls = C_CBZ;
  end

endmodule

`default_nettype wire

// File: rtl/cpu_control_fsm.sv
// +----------------------------------------------------------------------+
// | cpu_control_fsm : multi-cycle LEGv8 control unit driving the datapath |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int BR_W = 26
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            Zero,
  output logic [4:0]      Rd,
  output logic [4:0]      Rm,
  output logic [4:0]      Rn,
  output logic [11:0]     AddI12,
  output logic            Reg2Loc,
  output logic            ALUSrc,
  output logic [2:0]      ALUOp,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            MemToReg,
  output logic            pc_update,
  output logic            br_taken,
  output logic [BR_W-1:0] br_imm,
  output logic            flag_z,
  output logic            illegal
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [31:0]  r_instr;
  logic         r_flag_z;
  logic         r_br_taken;
  instr_class_t w_class;
  logic         w_accept;

  instr_classify u_classify (
    .opcode (r_instr[31:21]),
    .cls    (w_class)
  );

  assign w_accept = (r_state == IDLE) && instr_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction latch and the flags resolved during EXEC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr    <= '0;
      r_flag_z   <= 1'b0;
      r_br_taken <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr    <= instr;
        r_br_taken <= 1'b0;
      end
      if (r_state == EXEC) begin
        case (w_class)
          C_ADDS, C_SUBS: r_flag_z   <= Zero;
          C_CBZ:          r_br_taken <= Zero;
          C_B:            r_br_taken <= 1'b1;
          default:        ;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (instr_valid) w_state_nxt = DECODE;
      DECODE: w_state_nxt = (w_class == C_ILL) ? DONE : EXEC;
      EXEC: begin
        case (w_class)
          C_LDUR, C_STUR: w_state_nxt = MEM;
          C_B, C_CBZ:     w_state_nxt = DONE;
          default:        w_state_nxt = WB;
        endcase
      end
      MEM:     w_state_nxt = (w_class == C_STUR) ? DONE : WB;
      WB:      w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ALU controls hold from EXEC through WB so the ALU result is stable at writeback.
  always_comb begin
    instr_ready = 1'b0;
    Reg2Loc     = 1'b0;
    ALUSrc      = 1'b0;
    ALUOp       = ALU_PASSB;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    pc_update   = 1'b0;
    br_taken    = 1'b0;
    illegal     = 1'b0;

    case (r_state)
      IDLE: instr_ready = 1'b1;
      EXEC, MEM, WB: begin
        if (is_imm_alu_class(w_class)) begin
          ALUSrc = 1'b1;
          ALUOp  = ALU_ADD;
        end else if (w_class == C_ADDS) begin
          Reg2Loc = 1'b1;
          ALUOp   = ALU_ADD;
        end else if (w_class == C_SUBS) begin
          Reg2Loc = 1'b1;
          ALUOp   = ALU_SUB;
        end
        if (r_state == MEM && w_class == C_STUR) MemWrite = 1'b1;
        if (r_state == WB) begin
          RegWrite = 1'b1;
          MemToReg = (w_class == C_LDUR);
        end
      end
      DONE: begin
        pc_update = 1'b1;
        br_taken  = r_br_taken;
        illegal   = (w_class == C_ILL);
      end
      default: ;
    endcase
  end

  assign Rd     = r_instr[4:0];
  assign Rn     = r_instr[9:5];
  assign Rm     = r_instr[20:16];
  assign flag_z = r_flag_z;

  always_comb begin
    case (w_class)
      C_ADDI:         AddI12 = r_instr[21:10];
      C_LDUR, C_STUR: AddI12 = {3'b000, r_instr[20:12]};
      default:        AddI12 = '0;
    endcase
  end

  always_comb begin
    case (w_class)
      C_B:     br_imm = BR_W'($signed(r_instr[25:0]));
      C_CBZ:   br_imm = BR_W'($signed(r_instr[23:5]));
      default: br_imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed spec cases plus random words
// checked cycle by cycle against a phase/latency model of the instruction set.
`default_nettype none

module tb_cpu_control_fsm;

  localparam int K_ADDI = 0, K_ADDS = 1, K_SUBS = 2, K_LDUR = 3;
  localparam int K_STUR = 4, K_B = 5, K_CBZ = 6, K_ILL = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        Zero = 1'b0;
  logic [4:0]  Rd, Rm, Rn;
  logic [11:0] AddI12;
  logic        Reg2Loc, ALUSrc, RegWrite, MemWrite, MemToReg;
  logic [2:0]  ALUOp;
  logic        pc_update, br_taken, flag_z, illegal;
  logic [25:0] br_imm;

  int  n_vec = 0;
  int  n_err = 0;
  bit  m_flag = 1'b0;

  always #5 clk = ~clk;

  cpu_control_fsm #(.BR_W(26)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Zero(Zero), .Rd(Rd), .Rm(Rm), .Rn(Rn),
    .AddI12(AddI12), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .pc_update(pc_update), .br_taken(br_taken), .br_imm(br_imm),
    .flag_z(flag_z), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] w);
    if (w[31:21] ==? 11'b1001000100?) return K_ADDI;
    if (w[31:21] ==? 11'b10101011000) return K_ADDS;
    if (w[31:21] ==? 11'b11101011000) return K_SUBS;
    if (w[31:21] ==? 11'b11111000010) return K_LDUR;
    if (w[31:21] ==? 11'b11111000000) return K_STUR;
    if (w[31:21] ==? 11'b000101?????) return K_B;
    if (w[31:21] ==? 11'b10110100???) return K_CBZ;
    return K_ILL;
  endfunction

  function automatic int latency_of(input int k);
    case (k)
      K_LDUR:     return 5;
      K_B, K_CBZ: return 3;
      K_ILL:      return 2;
      default:    return 4;
    endcase
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_ready"},  32'(instr_ready), 32'd1);
    chk({tag, "_pc"},     32'(pc_update),   32'd0);
    chk({tag, "_regwr"},  32'(RegWrite),    32'd0);
    chk({tag, "_memwr"},  32'(MemWrite),    32'd0);
    chk({tag, "_alu"},    32'({Reg2Loc, ALUSrc, ALUOp, MemToReg}), 32'd0);
    chk({tag, "_ill"},    32'(illegal),     32'd0);
    chk({tag, "_flagz"},  32'(flag_z),      32'(m_flag));
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_instr(input logic [31:0] w, input logic z);
    int          kind, lat;
    logic [11:0] e_imm;
    logic [25:0] e_br;
    logic        e_r2l, e_src, e_taken;
    logic [2:0]  e_op;
    bit          win;

    kind = kind_of(w);
    lat  = latency_of(kind);
    e_imm = (kind == K_ADDI) ? w[21:10] :
            (kind == K_LDUR || kind == K_STUR) ? {3'b000, w[20:12]} : 12'd0;
    e_br  = (kind == K_B)   ? w[25:0] :
            (kind == K_CBZ) ? {{7{w[23]}}, w[23:5]} : 26'd0;
    e_src = (kind == K_ADDI || kind == K_LDUR || kind == K_STUR);
    e_r2l = (kind == K_ADDS || kind == K_SUBS);
    e_op  = (kind == K_SUBS) ? 3'b011 : (e_src || kind == K_ADDS) ? 3'b010 : 3'b000;
    e_taken = (kind == K_B) || (kind == K_CBZ && z);

    idle_checks("pre");
    instr = w; instr_valid = 1'b1; Zero = z;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 3 && (kind == K_ADDS || kind == K_SUBS)) m_flag = z;
      win = (k >= 2) && (k <= lat - 1);
      chk("ready_busy", 32'(instr_ready), 32'd0);
      chk("rd",     32'(Rd),     32'(w[4:0]));
      chk("rn",     32'(Rn),     32'(w[9:5]));
      chk("rm",     32'(Rm),     32'(w[20:16]));
      chk("addi12", 32'(AddI12), 32'(e_imm));
      chk("alusrc", 32'(ALUSrc), 32'(win & e_src));
      chk("reg2loc",32'(Reg2Loc),32'(win & e_r2l));
      chk("aluop",  32'(ALUOp),  win ? 32'(e_op) : 32'd0);
      chk("regwrite", 32'(RegWrite),
          32'((k == lat - 1) && kind inside {K_ADDI, K_ADDS, K_SUBS, K_LDUR}));
      chk("memwrite", 32'(MemWrite), 32'((k == lat - 1) && kind == K_STUR));
      chk("memtoreg", 32'(MemToReg), 32'((k == lat - 1) && kind == K_LDUR));
      chk("pc_update", 32'(pc_update), 32'(k == lat));
      chk("illegal",   32'(illegal),   32'((k == lat) && kind == K_ILL));
      chk("flag_z",    32'(flag_z),    32'(m_flag));
      if (k == lat) begin
        chk("br_taken", 32'(br_taken), 32'(e_taken));
        chk("br_imm",   32'(br_imm),   32'(e_br));
      end
      // A fresh word stays valid while busy; it must not be accepted before IDLE.
      instr = $urandom;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word(input int kind);
    logic [31:0] w;
    w = $urandom;
    case (kind)
      K_ADDI: w[31:22] = 10'b1001000100;
      K_ADDS: w[31:21] = 11'b10101011000;
      K_SUBS: w[31:21] = 11'b11101011000;
      K_LDUR: w[31:21] = 11'b11111000010;
      K_STUR: w[31:21] = 11'b11111000000;
      K_B:    w[31:26] = 6'b000101;
      K_CBZ:  w[31:24] = 8'b10110100;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_checks("reset");
    chk("reset_brimm", 32'(br_imm), 32'd0);
    chk("reset_rd", 32'({Rd, Rn, Rm, AddI12}), 32'd0);
    reset = 1'b1;

    // Reset in the middle of an LDUR (asserted while in MEM).
    instr = 32'hF8408003; instr_valid = 1'b1; Zero = 1'b0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("mid_memtoreg_pre", 32'(ALUSrc), 32'd1);
    reset = 1'b0; instr_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      m_flag = 1'b0;
      idle_checks("midrst");
    end
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_instr(32'h91001401, 1'b0);  // ADDI X1,X0,#5
    run_instr(32'hEB010022, 1'b1);  // SUBS X2,X1,X1 with Zero=1
    run_instr(32'hF8008001, 1'b0);  // STUR X1,[X0,#8]
    run_instr(32'hF8408003, 1'b0);  // LDUR X3,[X0,#8]
    run_instr(32'hB4FFFFA2, 1'b1);  // CBZ X2,#-3 taken
    run_instr(32'hB4FFFFA2, 1'b0);  // CBZ X2,#-3 not taken
    run_instr(32'h14000010, 1'b0);  // B #+16
    run_instr(32'h00000000, 1'b1);  // illegal
    run_instr(32'hAB020041, 1'b0);  // ADDS clears flag_z

    // Randomized instructions.
    for (int i = 0; i < 60; i++) begin
      run_instr(rand_word($urandom_range(0, 7)), 1'($urandom));
    end

    instr_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
